fetch_queue: RTL and testbench

//  Parametrised successor of the fetch stage. It owns the fetch PC and issues word reads to a

---
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry instruction queue: owns the fetch PC, reads a 1-cycle
// synchronous instruction memory, and buffers {PC, instruction} so decode stalls don't stall fetch.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Redirect_En,
    input  logic [31:0]       Redirect_PC,
    input  logic              Deq_En,
    output logic              Imem_Req,
    output logic [ADDR_W-1:0] Imem_Addr,
    input  logic [31:0]       Imem_Rdata,
    output logic              Valid_F,
    output logic [31:0]       Instr_F,
    output logic [31:0]       PC_F,
    output logic [31:0]       PC_Plus_4_F
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [31:0]      r_fetch_pc_p0;
    logic             r_vld_p1;
    logic [31:0]      r_infl_pc_p1;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_pc_q    [DEPTH];
    logic [31:0]      r_instr_q [DEPTH];

    logic             w_deq;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W:0]   w_occ;
    logic             w_unused_rpc_lsb;

    assign w_unused_rpc_lsb = ^Redirect_PC[1:0];

    assign Valid_F = (r_count != '0);
    assign w_deq   = Valid_F & Deq_En;
    assign w_push  = r_vld_p1 & ~Redirect_En;
    assign w_pop   = w_deq & ~Redirect_En;

    // Credit rule: the in-flight read already owns a slot, a pop this cycle frees one.
    assign w_occ    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_vld_p1} - {{CNT_W{1'b0}}, w_deq};
    assign Imem_Req = ~RST & ~Redirect_En & (w_occ < DEPTH_L);
    assign Imem_Addr = r_fetch_pc_p0[ADDR_W+1:2];

    // ---- stage p0 -> p1: fetch PC, in-flight tracking, queue control ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_pc_p0 <= RESET_PC;
            r_vld_p1      <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (Redirect_En) begin
            r_fetch_pc_p0 <= {Redirect_PC[31:2], 2'b00};
            r_vld_p1      <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_vld_p1 <= Imem_Req;
            if (Imem_Req)
                r_fetch_pc_p0 <= r_fetch_pc_p0 + 32'd4;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---- stage p1 -> queue: issued PC and returned word (data path, no reset) ----
    always_ff @(posedge CLK) begin
        if (Imem_Req)
            r_infl_pc_p1 <= r_fetch_pc_p0;
        if (w_push) begin
            r_pc_q[r_wr_ptr]    <= r_infl_pc_p1;
            r_instr_q[r_wr_ptr] <= Imem_Rdata;
        end
    end

    // Head outputs read zero while empty, which also gives the reset values.
    assign PC_F        = Valid_F ? r_pc_q[r_rd_ptr]    : 32'h0;
    assign Instr_F     = Valid_F ? r_instr_q[r_rd_ptr] : 32'h0;
    assign PC_Plus_4_F = PC_F + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of the fetch/redirect rules.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 8;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              CLK;
    logic              RST;
    logic              Redirect_En;
    logic [31:0]       Redirect_PC;
    logic              Deq_En;
    logic              Imem_Req;
    logic [ADDR_W-1:0] Imem_Addr;
    logic [31:0]       Imem_Rdata;
    logic              Valid_F;
    logic [31:0]       Instr_F;
    logic [31:0]       PC_F;
    logic [31:0]       PC_Plus_4_F;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RST(RST), .Redirect_En(Redirect_En), .Redirect_PC(Redirect_PC),
        .Deq_En(Deq_En), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Rdata(Imem_Rdata),
        .Valid_F(Valid_F), .Instr_F(Instr_F), .PC_F(PC_F), .PC_Plus_4_F(PC_Plus_4_F)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory: synchronous read, one cycle latency.
    logic [31:0] mem [2**ADDR_W];
    always @(posedge CLK) if (Imem_Req) Imem_Rdata <= mem[Imem_Addr];

    int ncmp = 0;
    int nerr = 0;
    int nreq = 0;

    // Reference model state
    logic [31:0] m_fpc;
    bit          m_inf;
    logic [31:0] m_ipc;
    logic [31:0] mq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        logic [ADDR_W-1:0] idx;
        idx = pc[ADDR_W+1:2];
        return mem[idx];
    endfunction

    task automatic model_reset();
        m_fpc = RESET_PC;
        m_inf = 1'b0;
        m_ipc = 32'h0;
        mq.delete();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit deq);
        bit          v, d, rq;
        logic [31:0] epc, ein;
        Redirect_En = redir;
        Redirect_PC = rpc;
        Deq_En      = deq;
        #1;
        v   = (mq.size() != 0);
        epc = v ? mq[0] : 32'h0;
        ein = v ? instr_at(mq[0]) : 32'h0;
        d   = v & deq;
        rq  = !redir && ((mq.size() + int'(m_inf) - int'(d)) < DEPTH);
        chk("valid", {31'b0, Valid_F}, {31'b0, v});
        chk("pc",    PC_F, epc);
        chk("instr", Instr_F, ein);
        chk("pc4",   PC_Plus_4_F, epc + 32'd4);
        chk("req",   {31'b0, Imem_Req}, {31'b0, rq});
        chk("addr",  {{(32-ADDR_W){1'b0}}, Imem_Addr}, {{(32-ADDR_W){1'b0}}, m_fpc[ADDR_W+1:2]});
        if (Imem_Req) nreq++;
        if (redir) begin
            mq.delete();
            m_inf = 1'b0;
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            if (d) void'(mq.pop_front());
            if (m_inf) mq.push_back(m_ipc);
            if (rq) begin
                m_inf = 1'b1;
                m_ipc = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end else begin
                m_inf = 1'b0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // Assert reset (optionally mid-cycle), check immediate clear, release after an edge.
    task automatic do_reset(input bit mid);
        Redirect_En = 1'b0;
        Deq_En      = 1'b1;
        if (mid) #3;
        RST = 1'b1;
        #1;
        chk("rst_valid", {31'b0, Valid_F}, 32'h0);
        chk("rst_pc",    PC_F, 32'h0);
        chk("rst_instr", Instr_F, 32'h0);
        chk("rst_pc4",   PC_Plus_4_F, 32'h4);
        chk("rst_req",   {31'b0, Imem_Req}, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        RST         = 1'b1;
        Redirect_En = 1'b0;
        Redirect_PC = 32'h0;
        Deq_En      = 1'b0;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = $urandom;
        model_reset();

        // Reset release, continuous dequeue
        do_reset(1'b0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("t1_first_valid", {31'b0, Valid_F}, 32'h1);
        chk("t1_first_pc", PC_F, RESET_PC);
        for (int i = 0; i < 8; i++) step(0, 0, 1);

        // Decode stall: exactly DEPTH requests, then drain in order
        do_reset(1'b0);
        nreq = 0;
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("t2_reqs", nreq, DEPTH);
        chk("t2_head", PC_F, 32'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 1);

        // Redirect with three queued and one in flight
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(1, 32'h41, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("t3_target", PC_F, 32'h40);
        for (int i = 0; i < 4; i++) step(0, 0, 1);

        // Redirect together with dequeue at head 0x8
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        chk("t4_head8", PC_F, 32'h8);
        step(1, 32'h100, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("t4_target", PC_F, 32'h100);
        for (int i = 0; i < 3; i++) step(0, 0, 1);

        // Async reset pulse mid-cycle while streaming
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        do_reset(1'b1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("t5_restart", PC_F, RESET_PC);

        // PC wrap at the top of the address space
        step(1, 32'hFFFF_FFFC, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("t6_top_pc", PC_F, 32'hFFFF_FFFC);
        chk("t6_top_pc4", PC_Plus_4_F, 32'h0);
        step(0, 0, 1);
        chk("t6_wrap_pc", PC_F, 32'h0);

        // Random traffic: stalls, back-to-back redirects
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
